// File: rtl/mod_n_counter_updown_if.sv
// Request/status bundle for one mod-N up/down counter stage.
// The counter drives the slave side; the controller or upstream stage drives the master side.
interface mod_n_counter_updown_if #(
   parameter int unsigned MODULUS = 3
);
   localparam int unsigned WIDTH = (MODULUS < 2) ? 1 : $clog2(MODULUS);

   logic             incr_i;
   logic             decr_i;
   logic             load_i;
   logic [WIDTH-1:0] load_value_i;
   logic [WIDTH-1:0] count_o;
   logic             at_max_o;
   logic             at_zero_o;
   logic             wrap_up_o;
   logic             wrap_down_o;
   logic             load_err_o;

   modport master (
      output incr_i, decr_i, load_i, load_value_i,
      input  count_o, at_max_o, at_zero_o, wrap_up_o, wrap_down_o, load_err_o
   );

   modport slave (
      input  incr_i, decr_i, load_i, load_value_i,
      output count_o, at_max_o, at_zero_o, wrap_up_o, wrap_down_o, load_err_o
   );
endinterface

// File: rtl/mod_n_counter_updown.sv
// Modulo-N up/down counter with range-checked load, wrap/saturate mode
// and registered wrap/error pulses for chaining counter digits.
module mod_n_counter_updown #(
   parameter int unsigned MODULUS  = 3,
   parameter bit          SATURATE = 1'b0
) (
   input logic                    clk_i,
   input logic                    clear_i,
   mod_n_counter_updown_if.slave  bus
);
   localparam int unsigned WIDTH = (MODULUS < 2) ? 1 : $clog2(MODULUS);

   if (MODULUS < 2) begin : g_bad_modulus
      $error("mod_n_counter_updown: MODULUS must be at least 2");
   end

   // One extra bit so MODULUS itself is representable when MODULUS == 2**WIDTH.
   localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MODULUS - 1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_up_q, wrap_up_d;
   logic             wrap_down_q, wrap_down_d;
   logic             load_err_q, load_err_d;
   logic [WIDTH:0]   count_ext;

   assign count_ext = {1'b0, count_q};

   // Next-state: load beats incr/decr; simultaneous incr+decr cancel.
   always_comb begin
      count_d     = count_q;
      wrap_up_d   = 1'b0;
      wrap_down_d = 1'b0;
      load_err_d  = 1'b0;
      if (bus.load_i) begin
         if ({1'b0, bus.load_value_i} < MOD_W) begin
            count_d = bus.load_value_i;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (bus.incr_i && bus.decr_i) begin
         count_d = count_q;
      end else if (bus.incr_i) begin
         if (count_ext < MAX_W) begin
            count_d = WIDTH'(count_ext + (WIDTH+1)'(1));
         end else if (SATURATE == 1'b0) begin
            count_d   = '0;
            wrap_up_d = 1'b1;
         end
      end else if (bus.decr_i) begin
         if (count_ext != '0) begin
            count_d = WIDTH'(count_ext - (WIDTH+1)'(1));
         end else if (SATURATE == 1'b0) begin
            count_d     = WIDTH'(MAX_W);
            wrap_down_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge clear_i) begin
      if (clear_i) begin
         count_q     <= '0;
         wrap_up_q   <= 1'b0;
         wrap_down_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         count_q     <= count_d;
         wrap_up_q   <= wrap_up_d;
         wrap_down_q <= wrap_down_d;
         load_err_q  <= load_err_d;
      end
   end

   assign bus.count_o     = count_q;
   assign bus.at_max_o    = (count_ext == MAX_W);
   assign bus.at_zero_o   = (count_q == '0);
   assign bus.wrap_up_o   = wrap_up_q;
   assign bus.wrap_down_o = wrap_down_q;
   assign bus.load_err_o  = load_err_q;
endmodule

// File: tb/tb_mod_n_counter_updown.sv
// Bench for mod_n_counter_updown: vector tables pushed into a scoreboard
// queue at drive time and popped on the following falling edge.
module tb_mod_n_counter_updown;
   logic       clk = 1'b0;
   logic       clear = 1'b0;
   logic       incr = 1'b0, decr = 1'b0, load = 1'b0;
   logic [3:0] ld_val = '0;
   int         sel = 0;
   int         n_checks = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   mod_n_counter_updown_if #(.MODULUS(3))  if_m3 ();
   mod_n_counter_updown_if #(.MODULUS(5))  if_m5 ();
   mod_n_counter_updown_if #(.MODULUS(5))  if_m5s ();
   mod_n_counter_updown_if #(.MODULUS(6))  if_m6 ();
   mod_n_counter_updown_if #(.MODULUS(4))  if_m4 ();
   mod_n_counter_updown_if #(.MODULUS(10)) if_c0 ();
   mod_n_counter_updown_if #(.MODULUS(10)) if_c1 ();

   mod_n_counter_updown #(.MODULUS(3),  .SATURATE(1'b0)) u_m3  (.clk_i(clk), .clear_i(clear), .bus(if_m3));
   mod_n_counter_updown #(.MODULUS(5),  .SATURATE(1'b0)) u_m5  (.clk_i(clk), .clear_i(clear), .bus(if_m5));
   mod_n_counter_updown #(.MODULUS(5),  .SATURATE(1'b1)) u_m5s (.clk_i(clk), .clear_i(clear), .bus(if_m5s));
   mod_n_counter_updown #(.MODULUS(6),  .SATURATE(1'b0)) u_m6  (.clk_i(clk), .clear_i(clear), .bus(if_m6));
   mod_n_counter_updown #(.MODULUS(4),  .SATURATE(1'b0)) u_m4  (.clk_i(clk), .clear_i(clear), .bus(if_m4));
   mod_n_counter_updown #(.MODULUS(10), .SATURATE(1'b0)) u_c0  (.clk_i(clk), .clear_i(clear), .bus(if_c0));
   mod_n_counter_updown #(.MODULUS(10), .SATURATE(1'b0)) u_c1  (.clk_i(clk), .clear_i(clear), .bus(if_c1));

   assign if_m3.incr_i  = incr && (sel == 0);
   assign if_m3.decr_i  = decr && (sel == 0);
   assign if_m3.load_i  = load && (sel == 0);
   assign if_m3.load_value_i  = 2'(ld_val);
   assign if_m5.incr_i  = incr && (sel == 1);
   assign if_m5.decr_i  = decr && (sel == 1);
   assign if_m5.load_i  = load && (sel == 1);
   assign if_m5.load_value_i  = 3'(ld_val);
   assign if_m5s.incr_i = incr && (sel == 2);
   assign if_m5s.decr_i = decr && (sel == 2);
   assign if_m5s.load_i = load && (sel == 2);
   assign if_m5s.load_value_i = 3'(ld_val);
   assign if_m6.incr_i  = incr && (sel == 3);
   assign if_m6.decr_i  = decr && (sel == 3);
   assign if_m6.load_i  = load && (sel == 3);
   assign if_m6.load_value_i  = 3'(ld_val);
   assign if_m4.incr_i  = incr && (sel == 4);
   assign if_m4.decr_i  = decr && (sel == 4);
   assign if_m4.load_i  = load && (sel == 4);
   assign if_m4.load_value_i  = 2'(ld_val);
   assign if_c0.incr_i  = incr && (sel == 5);
   assign if_c0.decr_i  = decr && (sel == 5);
   assign if_c0.load_i  = load && (sel == 5);
   assign if_c0.load_value_i  = ld_val;
   // Second digit advances on the first digit's wrap pulse.
   assign if_c1.incr_i  = if_c0.wrap_up_o;
   assign if_c1.decr_i  = 1'b0;
   assign if_c1.load_i  = 1'b0;
   assign if_c1.load_value_i  = '0;

   logic [3:0] o_cnt;
   logic       o_mx, o_zr, o_wu, o_wd, o_le;
   always_comb begin
      o_cnt = '0; o_mx = 1'b0; o_zr = 1'b0; o_wu = 1'b0; o_wd = 1'b0; o_le = 1'b0;
      case (sel)
         0: begin o_cnt = 4'(if_m3.count_o);  o_mx = if_m3.at_max_o;  o_zr = if_m3.at_zero_o;  o_wu = if_m3.wrap_up_o;  o_wd = if_m3.wrap_down_o;  o_le = if_m3.load_err_o;  end
         1: begin o_cnt = 4'(if_m5.count_o);  o_mx = if_m5.at_max_o;  o_zr = if_m5.at_zero_o;  o_wu = if_m5.wrap_up_o;  o_wd = if_m5.wrap_down_o;  o_le = if_m5.load_err_o;  end
         2: begin o_cnt = 4'(if_m5s.count_o); o_mx = if_m5s.at_max_o; o_zr = if_m5s.at_zero_o; o_wu = if_m5s.wrap_up_o; o_wd = if_m5s.wrap_down_o; o_le = if_m5s.load_err_o; end
         3: begin o_cnt = 4'(if_m6.count_o);  o_mx = if_m6.at_max_o;  o_zr = if_m6.at_zero_o;  o_wu = if_m6.wrap_up_o;  o_wd = if_m6.wrap_down_o;  o_le = if_m6.load_err_o;  end
         4: begin o_cnt = 4'(if_m4.count_o);  o_mx = if_m4.at_max_o;  o_zr = if_m4.at_zero_o;  o_wu = if_m4.wrap_up_o;  o_wd = if_m4.wrap_down_o;  o_le = if_m4.load_err_o;  end
         default: begin o_cnt = if_c0.count_o; o_mx = if_c0.at_max_o; o_zr = if_c0.at_zero_o; o_wu = if_c0.wrap_up_o; o_wd = if_c0.wrap_down_o; o_le = if_c0.load_err_o; end
      endcase
   end

   typedef struct {
      bit incr, decr, load;
      int lv, cnt;
      bit mx, zr, wu, wd, le;
      int c2;
   } vec_t;

   vec_t sb_q[$];
   vec_t tbl[$];

   function automatic vec_t mk(bit i, bit d, bit l, int lv, int c, bit mx, bit zr,
                               bit wu, bit wd, bit le, int c2 = -1);
      vec_t v;
      v.incr = i; v.decr = d; v.load = l; v.lv = lv; v.cnt = c;
      v.mx = mx; v.zr = zr; v.wu = wu; v.wd = wd; v.le = le; v.c2 = c2;
      return v;
   endfunction

   task automatic check(input string nm, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   task automatic check_out(input string tag);
      vec_t e;
      if (sb_q.size() == 0) begin
         check({tag, " scoreboard_empty"}, 0, 1);
         return;
      end
      e = sb_q.pop_front();
      check({tag, " count"},     int'(o_cnt), e.cnt);
      check({tag, " at_max"},    int'(o_mx),  int'(e.mx));
      check({tag, " at_zero"},   int'(o_zr),  int'(e.zr));
      check({tag, " wrap_up"},   int'(o_wu),  int'(e.wu));
      check({tag, " wrap_down"}, int'(o_wd),  int'(e.wd));
      check({tag, " load_err"},  int'(o_le),  int'(e.le));
      if (e.c2 >= 0) check({tag, " stage2_count"}, int'(if_c1.count_o), e.c2);
   endtask

   task automatic apply(input vec_t v, input string tag);
      incr = v.incr; decr = v.decr; load = v.load; ld_val = 4'(v.lv);
      sb_q.push_back(v);
      @(negedge clk);
      check_out(tag);
   endtask

   task automatic run_table(input string name);
      foreach (tbl[k]) apply(tbl[k], $sformatf("%s[%0d]", name, k));
      tbl.delete();
      incr = 1'b0; decr = 1'b0; load = 1'b0; ld_val = '0;
   endtask

   task automatic do_reset(input string name);
      incr = 1'b0; decr = 1'b0; load = 1'b0; ld_val = '0;
      clear = 1'b1;
      #1;
      sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, (sel == 5) ? 0 : -1));
      check_out({name, " reset"});
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      @(negedge clk);

      // Mod-3 wrapping up-count.
      sel = 0;
      do_reset("m3");
      tbl.push_back(mk(1,0,0,0, 1, 0,0, 0,0,0));
      tbl.push_back(mk(1,0,0,0, 2, 1,0, 0,0,0));
      tbl.push_back(mk(1,0,0,0, 0, 0,1, 1,0,0));
      tbl.push_back(mk(1,0,0,0, 1, 0,0, 0,0,0));
      tbl.push_back(mk(1,0,0,0, 2, 1,0, 0,0,0));
      tbl.push_back(mk(1,0,0,0, 0, 0,1, 1,0,0));
      tbl.push_back(mk(1,0,0,0, 1, 0,0, 0,0,0));
      tbl.push_back(mk(0,0,0,0, 1, 0,0, 0,0,0));
      run_table("m3_up");

      // Mod-5 wrapping down-count.
      sel = 1;
      do_reset("m5");
      tbl.push_back(mk(0,1,0,0, 4, 1,0, 0,1,0));
      tbl.push_back(mk(0,1,0,0, 3, 0,0, 0,0,0));
      tbl.push_back(mk(0,1,0,0, 2, 0,0, 0,0,0));
      tbl.push_back(mk(0,1,0,0, 1, 0,0, 0,0,0));
      tbl.push_back(mk(0,1,0,0, 0, 0,1, 0,0,0));
      tbl.push_back(mk(0,1,0,0, 4, 1,0, 0,1,0));
      tbl.push_back(mk(0,0,0,0, 4, 1,0, 0,0,0));
      run_table("m5_down");

      // Mod-5 saturating at both ends.
      sel = 2;
      do_reset("m5s");
      tbl.push_back(mk(0,0,1,4, 4, 1,0, 0,0,0));
      for (int k = 0; k < 3; k++) tbl.push_back(mk(1,0,0,0, 4, 1,0, 0,0,0));
      tbl.push_back(mk(0,1,0,0, 3, 0,0, 0,0,0));
      tbl.push_back(mk(0,1,0,0, 2, 0,0, 0,0,0));
      tbl.push_back(mk(0,1,0,0, 1, 0,0, 0,0,0));
      for (int k = 0; k < 3; k++) tbl.push_back(mk(0,1,0,0, 0, 0,1, 0,0,0));
      run_table("m5_sat");

      // Mod-6 load priority and range check.
      sel = 3;
      do_reset("m6");
      tbl.push_back(mk(1,0,1,3, 3, 0,0, 0,0,0));
      tbl.push_back(mk(0,0,1,7, 3, 0,0, 0,0,1));
      tbl.push_back(mk(1,1,0,0, 3, 0,0, 0,0,0));
      tbl.push_back(mk(0,1,1,6, 3, 0,0, 0,0,1));
      tbl.push_back(mk(0,0,1,7, 3, 0,0, 0,0,1));
      tbl.push_back(mk(0,0,1,5, 5, 1,0, 0,0,0));
      tbl.push_back(mk(1,0,1,0, 0, 0,1, 0,0,0));
      tbl.push_back(mk(0,1,0,0, 5, 1,0, 0,1,0));
      run_table("m6_load");

      // Mod-4 (power of two) with an asynchronous clear between edges.
      sel = 4;
      do_reset("m4");
      tbl.push_back(mk(0,1,0,0, 3, 1,0, 0,1,0));
      run_table("m4_pre");
      #2 clear = 1'b1;
      #1;
      sb_q.push_back(mk(0,0,0,0, 0, 0,1, 0,0,0));
      check_out("m4 async_clear");
      #1 clear = 1'b0;
      tbl.push_back(mk(1,0,0,0, 1, 0,0, 0,0,0));
      tbl.push_back(mk(1,0,0,0, 2, 0,0, 0,0,0));
      tbl.push_back(mk(1,0,0,0, 3, 1,0, 0,0,0));
      tbl.push_back(mk(1,0,0,0, 0, 0,1, 1,0,0));
      tbl.push_back(mk(0,0,0,0, 0, 0,1, 0,0,0));
      run_table("m4_post");

      // Two mod-10 digits chained through the wrap pulse.
      sel = 5;
      do_reset("casc");
      for (int k = 1; k <= 25; k++)
         tbl.push_back(mk(1,0,0,0, k % 10, (k % 10) == 9, (k % 10) == 0,
                          (k % 10) == 0, 0, 0, (k - 1) / 10));
      tbl.push_back(mk(0,0,0,0, 5, 0,0, 0,0,0, 2));
      run_table("casc");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mod_n_counter_updown.md
Name: mod_n_counter_updown

Overview:
- Parametrised synchronous modulo-N up/down counter; the next generation of the fixed mod-3 counter.
- Adds:
  - arbitrary modulus;
  - increment and decrement;
  - synchronous load with range checking;
  - wrap or saturate mode;
  - registered wrap/error pulses for cascading counters into multi-digit chains.
- Sits in the mod_n_counter_sync family; instances chain via wrap pulses driving the next stage's incr_i/decr_i.

Parameters:
- MODULUS, 3, count range 0..MODULUS-1; legal MODULUS >= 2.
- SATURATE, 0, 0 = wrap at the ends; 1 = hold at the ends.
- WIDTH (localparam), $clog2(MODULUS), width of count and load value.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- clear_i  input  1  asynchronous active-high reset.
- incr_i  input  1  count-up request for this cycle.
- decr_i  input  1  count-down request for this cycle.
- load_i  input  1  synchronous load request.
- load_value_i  input  WIDTH  value to load when load_i=1.
- count_o  output  WIDTH  current count (registered).
- at_max_o  output  1  combinational: count_o == MODULUS-1.
- at_zero_o  output  1  combinational: count_o == 0.
- wrap_up_o  output  1  registered one-cycle pulse: the previous cycle wrapped MODULUS-1 -> 0.
- wrap_down_o  output  1  registered one-cycle pulse: the previous cycle wrapped 0 -> MODULUS-1.
- load_err_o  output  1  registered one-cycle pulse: the previous cycle rejected an out-of-range load.

Behaviour:
- Reset: clear_i=1 immediately (no clock needed) forces count_o=0, wrap_up_o=0, wrap_down_o=0, load_err_o=0. at_zero_o=1 and at_max_o=0 follow combinationally.
  - Reset asserted mid-operation overrides everything.
  - The first update after deassertion occurs on the first rising edge with clear_i=0.
- Priority per rising edge, highest first:
  1. load_i=1:
     - if load_value_i < MODULUS, count <= load_value_i;
     - else count is unchanged and load_err_o=1 next cycle.
     - incr_i/decr_i are ignored this cycle whether or not the load is accepted.
     - No wrap pulse on a load.
  2. incr_i=1 and decr_i=1: no change, no pulses.
  3. incr_i=1:
     - count < MODULUS-1: count+1.
     - count = MODULUS-1, SATURATE=0: count <= 0, wrap_up_o=1 next cycle.
     - count = MODULUS-1, SATURATE=1: hold, no pulse.
  4. decr_i=1:
     - count > 0: count-1.
     - count = 0, SATURATE=0: count <= MODULUS-1, wrap_down_o=1 next cycle.
     - count = 0, SATURATE=1: hold, no pulse.
  5. None asserted: hold.
- Latency: count_o reflects a request one cycle after the edge that samples it. Pulses appear on the same edge as the resulting count value.
- Pulses are high for exactly one cycle per event. Back-to-back wrap events give back-to-back pulses with no gap.
- Arithmetic: next-state comparisons use WIDTH+1 bits so no intermediate overflow.
  - The count never holds a value >= MODULUS, including non-power-of-2 MODULUS.
  - Codes MODULUS..2^WIDTH-1 are unreachable.
- MODULUS = 2^WIDTH: wrap is still detected explicitly (at_max), not by natural overflow.
- Elaboration fails if MODULUS < 2.
- Intended RTL size: ~150 lines.

Test Plan:
- Reset, then MODULUS=3, SATURATE=0, incr_i held 7 cycles.
  - count_o sequence 1,2,0,1,2,0,1.
  - wrap_up_o high exactly in the cycles count_o=0 (2 pulses).
  - at_max_o high when count_o=2.
- MODULUS=5, SATURATE=0, reset then decr_i held 6 cycles.
  - count_o sequence 4,3,2,1,0,4.
  - wrap_down_o pulses with the first and the last (sixth) count_o=4.
  - at_zero_o high when count_o=0.
- MODULUS=5, SATURATE=1.
  - Load 4 then incr_i 3 cycles: count_o stays 4, wrap_up_o never asserts.
  - Then decr_i 6 cycles: count_o 3,2,1,0,0,0, no wrap_down_o.
- MODULUS=6.
  - load_i=1, load_value_i=3 with incr_i=1: count_o=3, no wrap.
  - Then load_value_i=7: count_o stays 3, load_err_o pulses one cycle.
  - Then incr_i=decr_i=1: count_o stays 3.
- MODULUS=4.
  - Count to 3 and assert clear_i asynchronously between edges: count_o=0 and all pulses 0 before the next edge.
  - Deassert; incr_i gives count_o=1 on the first edge.
  - Incr from 3 gives 0 with wrap_up_o.
- Cascade two instances (MODULUS=10) with the first stage's wrap_up_o driving the second stage's incr_i. Apply 25 increments, then hold incr_i low for one edge.
  - Second-stage count_o=2, first-stage count_o=5.
  - The second stage advances one cycle after each first-stage wrap.
